// File: rtl/dsram_like_responder.sv
// SRAM-like data-side slave: accepts requests on an address handshake, commits writes at
// acceptance and returns in-order responses after LATENCY cycles. Optional: DSRAM_RAND_DELAY_EN.
module dsram_like_responder #(
  parameter int AW      = 14,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  logic [31:0]   mem_q [2**AW];
  logic [31:0]   rd_word_q;
  logic [AW-1:0] word_idx;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          fill_vld_q, fill_vld_d, fill_wr_q, fill_wr_d;
  logic [PW-1:0] fill_slot_q, fill_slot_d;
  logic          data_ok_q, data_ok_d, byp_q, byp_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [4:0]    slot_cnt  [QDEPTH];
  logic [31:0]   slot_data [QDEPTH];
  logic [4:0]    load_cnt, store_cnt;
  logic          slot_free, accept, head_valid, pop_queued, pop_bypass, pop;
  logic [31:0]   fill_word, head_data;
  logic          unused_ok;

  assign unused_ok = ^{data_sram_size, data_sram_addr[31:AW+2], data_sram_addr[1:0]};
  assign word_idx  = data_sram_addr[AW+1:2];

`ifdef DSRAM_RAND_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign load_cnt  = 5'(LATENCY - 1) + {3'b000, lfsr_q[1:0]};
  assign slot_free = (count_q < QFULL) && (lfsr_q[4:2] != 3'b000);
`else
  assign load_cnt  = 5'(LATENCY - 1);
  assign slot_free = count_q < QFULL;
`endif

  assign data_sram_addr_ok = ~reset & slot_free;
  assign accept            = data_sram_req & data_sram_addr_ok;

  // The acceptance cycle already counts as the first countdown cycle, so the
  // stored count is one less than the load value and a zero-delay request
  // arriving at an empty queue is popped straight away.
  assign store_cnt = (load_cnt == 5'd0) ? 5'd0 : load_cnt - 5'd1;

  // Read data lands in rd_word_q one cycle after acceptance; fill_word is the
  // value the entry accepted last cycle carries (writes respond with zero).
  assign fill_word = fill_wr_q ? 32'd0 : rd_word_q;
  assign head_data = (fill_vld_q && fill_slot_q == head_q) ? fill_word : slot_data[head_q];

  assign data_sram_data_ok = data_ok_q;
  assign data_sram_rdata   = byp_q ? fill_word : rdata_q;

  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) mem_q[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
    rd_word_q <= mem_q[word_idx];
  end

  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_slot
    logic [4:0]    cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic [PW-1:0] rel;
    logic          valid;

    always_comb begin
      rel   = PW'(gi) - head_q;
      valid = {1'b0, rel} < count_q;
      cnt_d = cnt_q;
      if (accept && tail_q == PW'(gi)) cnt_d = store_cnt;
      else if (valid && cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
      data_d = data_q;
      if (fill_vld_q && fill_slot_q == PW'(gi)) data_d = fill_word;
    end

    always_ff @(posedge clk) begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end

    assign slot_cnt[gi]  = cnt_q;
    assign slot_data[gi] = data_q;
  end

  always_comb begin
    head_valid  = count_q != '0;
    pop_queued  = head_valid && slot_cnt[head_q] == 5'd0;
    pop_bypass  = accept && !head_valid && load_cnt == 5'd0;
    pop         = pop_queued | pop_bypass;
    head_d      = pop    ? head_q + 1'b1 : head_q;
    tail_d      = accept ? tail_q + 1'b1 : tail_q;
    count_d     = count_q;
    if (accept && !pop)      count_d = count_q + 1'b1;
    else if (pop && !accept) count_d = count_q - 1'b1;
    fill_vld_d  = accept;
    fill_wr_d   = data_sram_wr;
    fill_slot_d = tail_q;
    data_ok_d   = pop;
    byp_d       = pop_bypass;
    rdata_d     = data_sram_rdata;
    if (pop_queued) rdata_d = head_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      fill_vld_q  <= 1'b0;
      fill_wr_q   <= 1'b0;
      fill_slot_q <= '0;
      data_ok_q   <= 1'b0;
      byp_q       <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      fill_vld_q  <= fill_vld_d;
      fill_wr_q   <= fill_wr_d;
      fill_slot_q <= fill_slot_d;
      data_ok_q   <= data_ok_d;
      byp_q       <= byp_d;
      rdata_q     <= rdata_d;
    end
  end
endmodule

// File: tb/tb_dsram_like_responder.sv
// Bench: three responders (LATENCY 2, 8, 1; QDEPTH 4) share one stimulus stream, each checked
// against a transaction-level model of due cycles, occupancy and memory contents.
module tb_dsram_like_responder;
  localparam int NI = 3;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          has_exp;
    logic [31:0] exp;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  bit          hx = 1'b0;
  logic [31:0] ex = '0;

  logic [NI-1:0]       aok, dok;
  logic [NI-1:0][31:0] rdat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 2 : ((gi == 1) ? 8 : 1);

    dsram_like_responder #(.AW(8), .LATENCY(L), .QDEPTH(4)) u_dut (
      .clk               (clk),
      .reset             (rst),
      .data_sram_req     (req),
      .data_sram_wr      (wr),
      .data_sram_size    (2'd2),
      .data_sram_addr    (addr),
      .data_sram_wstrb   (wstrb),
      .data_sram_wdata   (wdata),
      .data_sram_addr_ok (aok[gi]),
      .data_sram_data_ok (dok[gi]),
      .data_sram_rdata   (rdat[gi])
    );

    // Model: response for an accept in cycle c is due at max(c+L, previous due+1);
    // an entry occupies a slot from the cycle after acceptance until its due cycle.
    initial begin : chk
      resp_t       pend[$];
      resp_t       ent;
      logic [31:0] mem_m [256];
      logic [31:0] last_rd;
      int          cyc, last_due, n_in, idx, due;
      bit          exp_aok;
      cyc = 0;
      last_due = 0;
      last_rd = 32'd0;
      forever begin
        @(negedge clk);
        #1;
        n_in = pend.size();
        if (n_in > 0 && pend[0].due == cyc) n_in--;
        exp_aok = !rst && (n_in < 4);
        checks++;
        if (aok[gi] !== exp_aok) begin
          errors++;
          $display("FAIL addr_ok L=%0d cyc=%0d got=%b exp=%b", L, cyc, aok[gi], exp_aok);
        end
        if (pend.size() > 0 && pend[0].due == cyc) begin
          ent = pend.pop_front();
          checks++;
          if (dok[gi] !== 1'b1 || rdat[gi] !== ent.data) begin
            errors++;
            $display("FAIL response L=%0d cyc=%0d got data_ok=%b rdata=%h exp data_ok=1 rdata=%h",
                     L, cyc, dok[gi], rdat[gi], ent.data);
          end else begin
            $display("rsp L=%0d cyc=%0d rdata=%h", L, cyc, rdat[gi]);
          end
          if (ent.has_exp) begin
            checks++;
            if (rdat[gi] !== ent.exp) begin
              errors++;
              $display("FAIL vector L=%0d cyc=%0d got=%h exp=%h", L, cyc, rdat[gi], ent.exp);
            end
          end
          last_rd = ent.data;
        end else begin
          checks++;
          if (dok[gi] !== 1'b0 || rdat[gi] !== last_rd) begin
            errors++;
            $display("FAIL idle L=%0d cyc=%0d got data_ok=%b rdata=%h exp data_ok=0 rdata=%h",
                     L, cyc, dok[gi], rdat[gi], last_rd);
          end
        end
        if (rst) begin
          pend.delete();
          last_rd  = 32'd0;
          last_due = 0;
        end else if (req && exp_aok) begin
          idx = int'(addr[9:2]);
          due = (cyc + L > last_due + 1) ? cyc + L : last_due + 1;
          ent.due     = due;
          ent.data    = wr ? 32'd0 : mem_m[idx];
          ent.has_exp = hx;
          ent.exp     = ex;
          pend.push_back(ent);
          last_due = due;
          if (wr) begin
            for (int b = 0; b < 4; b++) begin
              if (wstrb[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
            end
          end
        end
        cyc++;
      end
    end
  end

  task automatic drive(input bit rs, input bit r, input bit w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d, input bit h, input logic [31:0] e);
    @(negedge clk);
    rst = rs; req = r; wr = w; addr = a; wstrb = s; wdata = d; hx = h; ex = e;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin : drv
    vec_t        tbl [7];
    logic [31:0] a;
    tbl[0] = '{1'b0, 32'h0000_0040, 4'h0, 32'h0,          32'h1234_5678};
    tbl[1] = '{1'b1, 32'h0000_0041, 4'h2, 32'h0000_AB00, 32'h0};
    tbl[2] = '{1'b0, 32'h0000_0040, 4'h0, 32'h0,          32'h1234_AB78};
    tbl[3] = '{1'b1, 32'h0000_0080, 4'hF, 32'hDEAD_BEEF, 32'h0};
    tbl[4] = '{1'b0, 32'h0000_0080, 4'h0, 32'h0,          32'hDEAD_BEEF};
    tbl[5] = '{1'b1, 32'h0000_0042, 4'hC, 32'hCAFE_0000, 32'h0};
    tbl[6] = '{1'b0, 32'hFFFF_FC43, 4'h0, 32'h0,          32'hCAFE_AB78};

    repeat (3) drive(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 32'd0);

    // preload words 0..31, spaced so every instance accepts each write
    for (int w = 0; w < 32; w++) begin
      drive(1'b0, 1'b1, 1'b1, 32'(w) << 2, 4'hF, (w == 16) ? 32'h1234_5678 : $urandom(), 1'b1, 32'd0);
      idle(9);
    end

    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, tbl[i].wr, tbl[i].addr, tbl[i].wstrb, tbl[i].wdata, 1'b1, tbl[i].exp);
      idle(10);
    end

    // read-after-write in consecutive cycles
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0080, 4'hF, 32'h5555_AAAA, 1'b1, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0080, 4'h0, 32'd0, 1'b1, 32'h5555_AAAA);
    idle(12);

    // streaming / full queue: req held for ten reads of words 0..9
    for (int w = 0; w < 10; w++) drive(1'b0, 1'b1, 1'b0, 32'(w) << 2, 4'h0, 32'd0, 1'b0, 32'd0);
    idle(15);

    // reset while three reads are outstanding
    for (int w = 0; w < 3; w++) drive(1'b0, 1'b1, 1'b0, 32'(w + 16) << 2, 4'h0, 32'd0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 32'd0);
    idle(12);

    for (int n = 0; n < 600; n++) begin
      a = $urandom();
      a[9:7] = 3'b000;
      a[6:2] = 5'($urandom_range(31, 0));
      drive($urandom_range(99, 0) == 0, $urandom_range(9, 0) < 6, $urandom_range(9, 0) < 3,
            a, 4'($urandom()), $urandom(), 1'b0, 32'd0);
    end
    idle(20);

    @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
